// File: rtl/pixel_fetch_if.sv
// pixel_fetch_if
//   Read port of a first-word-fall-through pixel FIFO.
//   fifo_data  : head word, bit DATA_W is the start-of-frame tag and
//                bits [DATA_W-1:0] are RGB; valid only while !fifo_empty
//   fifo_empty : FIFO holds no words
//   fifo_rd    : pop strobe from the reader, consumes the head word
//   master modport is the reader (pixel_fetch), slave modport is the FIFO.
interface pixel_fetch_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W:0] fifo_data;
  logic            fifo_empty;
  logic            fifo_rd;

  modport master (
    input  fifo_data,
    input  fifo_empty,
    output fifo_rd
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    input  fifo_rd
  );
endinterface

// File: rtl/pixel_fetch.sv
// pixel_fetch
//   Pulls pixels from an FWFT FIFO in step with the raw video timing and
//   presents a registered RGB stream with syncs delayed to match. The
//   stream is locked to frame boundaries with the SOF tag carried in each
//   FIFO word; FIFO starvation and SOF misalignment are counted and
//   recovered from by dropping out of lock for the rest of the frame and
//   re-seeking the next SOF.
// Ports
//   clk, rst      : pixel clock, asynchronous active-high reset
//   vs_in/hs_in/de_in : timing from the sync generator
//   fifo          : FIFO read port (fifo_data, fifo_empty, fifo_rd)
//   vs_out/hs_out/de_out : timing delayed by one clock
//   rgb_out       : registered pixel aligned with de_out; FILL_COLOR on
//                   active pixels not sourced from the FIFO, 0 in blanking
//   locked        : high while streaming frame-aligned pixels
//   underflow_cnt : saturating count of FIFO starvation events
//   sof_err_cnt   : saturating count of SOF misalignment events
module pixel_fetch #(
  parameter int                 DATA_W     = 24,
  parameter logic [DATA_W-1:0]  FILL_COLOR = '0,
  parameter int                 CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  pixel_fetch_if.master     fifo,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [DATA_W-1:0] rgb_out,
  output logic              locked,
  output logic [CNT_W-1:0]  underflow_cnt,
  output logic [CNT_W-1:0]  sof_err_cnt
);

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    ARMED  = 2'd1,
    RUN    = 2'd2,
    STARVE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              first_px;
  logic              first_nxt;
  logic              first_eff;
  logic              take;
  logic              pop;
  logic              px_pop;
  logic              uf_evt;
  logic              sof_evt;
  logic              vs_rise;
  logic              head_sof;
  logic [DATA_W-1:0] head_rgb;
  logic [DATA_W-1:0] pix_nxt;

  // vs_out is the registered copy of vs_in, so it doubles as vs_d.
  assign vs_rise  = vs_in & ~vs_out;
  assign head_sof = fifo.fifo_data[DATA_W];
  assign head_rgb = fifo.fifo_data[DATA_W-1:0];

  always_comb begin
    state_nxt = state;
    first_nxt = first_px;
    first_eff = first_px;
    take      = 1'b0;
    pop       = 1'b0;
    px_pop    = 1'b0;
    uf_evt    = 1'b0;
    sof_evt   = 1'b0;

    unique case (state)
      SEEK: begin
        if (!fifo.fifo_empty) begin
          if (head_sof) state_nxt = ARMED;
          else          pop       = 1'b1;
        end
      end
      // A vs_rise is acted on before de_in, so an active pixel on the same
      // cycle is handled as the first pixel of the new frame.
      ARMED: begin
        if (vs_rise) begin
          state_nxt = RUN;
          first_nxt = 1'b1;
          first_eff = 1'b1;
          take      = de_in;
        end
      end
      RUN: begin
        if (vs_rise) begin
          first_nxt = 1'b1;
          first_eff = 1'b1;
        end
        take = de_in;
      end
      STARVE: begin
        if (vs_rise) state_nxt = SEEK;
      end
      default: state_nxt = SEEK;
    endcase

    // The head must carry SOF exactly when a frame's first pixel is due.
    if (take) begin
      if (fifo.fifo_empty) begin
        uf_evt    = 1'b1;
        state_nxt = STARVE;
      end else if (first_eff != head_sof) begin
        sof_evt   = 1'b1;
        state_nxt = STARVE;
      end else begin
        pop       = 1'b1;
        px_pop    = 1'b1;
        first_nxt = 1'b0;
      end
    end
  end

  always_comb begin
    pix_nxt = '0;
    if (de_in) pix_nxt = px_pop ? head_rgb : FILL_COLOR;
  end

  assign fifo.fifo_rd = pop & ~rst;
  assign locked       = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= SEEK;
      first_px      <= 1'b0;
      vs_out        <= 1'b0;
      hs_out        <= 1'b0;
      de_out        <= 1'b0;
      rgb_out       <= '0;
      underflow_cnt <= '0;
      sof_err_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      first_px <= first_nxt;
      vs_out   <= vs_in;
      hs_out   <= hs_in;
      de_out   <= de_in;
      rgb_out  <= pix_nxt;
      if (uf_evt && (underflow_cnt != '1))
        underflow_cnt <= underflow_cnt + CNT_W'(1);
      if (sof_evt && (sof_err_cnt != '1))
        sof_err_cnt <= sof_err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pixel_fetch.sv
module tb_pixel_fetch;
  localparam int              DATA_W = 24;
  localparam int              CNT_W  = 4;
  localparam logic [23:0]     FILL   = 24'hABCDEF;
  localparam int              SAT    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              vs_in, hs_in, de_in;
  logic              vs_out, hs_out, de_out;
  logic [DATA_W-1:0] rgb_out;
  logic              locked;
  logic [CNT_W-1:0]  underflow_cnt, sof_err_cnt;

  pixel_fetch_if #(.DATA_W(DATA_W)) fifo_bus ();

  pixel_fetch #(
    .DATA_W    (DATA_W),
    .FILL_COLOR(FILL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vs_in        (vs_in),
    .hs_in        (hs_in),
    .de_in        (de_in),
    .fifo         (fifo_bus),
    .vs_out       (vs_out),
    .hs_out       (hs_out),
    .de_out       (de_out),
    .rgb_out      (rgb_out),
    .locked       (locked),
    .underflow_cnt(underflow_cnt),
    .sof_err_cnt  (sof_err_cnt)
  );

  always #5 clk = ~clk;

  int npass  = 0;
  int ntotal = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Bench-owned FIFO contents; head is q[0].
  logic [DATA_W:0]   q[$];
  logic [DATA_W-1:0] seen[$];
  logic              rd_seen = 1'b0;
  logic              en = 1'b0;

  // Model: mode 0 hunting for SOF, 1 holding SOF for next frame,
  // 2 streaming, 3 sitting out the rest of a broken frame.
  int                m_mode, n_mode;
  bit                m_first, n_first;
  int                m_uf, n_uf, m_se, n_se;
  logic              m_vs, n_vs, m_hs, n_hs, m_de, n_de;
  logic [DATA_W-1:0] m_rgb, n_rgb;
  logic              exp_rd;

  function automatic void model_reset();
    m_mode = 0; m_first = 0; m_uf = 0; m_se = 0;
    m_vs = 0; m_hs = 0; m_de = 0; m_rgb = '0;
    n_mode = 0; n_first = 0; n_uf = 0; n_se = 0;
    n_vs = 0; n_hs = 0; n_de = 0; n_rgb = '0;
    exp_rd = 0;
  endfunction

  function automatic void model_commit();
    m_mode = n_mode; m_first = n_first; m_uf = n_uf; m_se = n_se;
    m_vs = n_vs; m_hs = n_hs; m_de = n_de; m_rgb = n_rgb;
  endfunction

  function automatic void take_pixel(bit first);
    if (q.size() == 0) begin
      if (n_uf < SAT) n_uf++;
      n_mode = 3;
    end else if (first != q[0][DATA_W]) begin
      if (n_se < SAT) n_se++;
      n_mode = 3;
    end else begin
      exp_rd  = 1;
      n_rgb   = q[0][DATA_W-1:0];
      n_first = 0;
    end
  endfunction

  function automatic void model_eval();
    bit rise;
    if (rst) begin
      model_reset();
      return;
    end
    rise    = vs_in && !m_vs;
    exp_rd  = 0;
    n_vs    = vs_in; n_hs = hs_in; n_de = de_in;
    n_rgb   = de_in ? FILL : '0;
    n_mode  = m_mode; n_first = m_first; n_uf = m_uf; n_se = m_se;
    if (m_mode == 0) begin
      if (q.size() != 0) begin
        if (q[0][DATA_W]) n_mode = 1;
        else              exp_rd = 1;
      end
    end else if (m_mode == 1) begin
      if (rise) begin
        n_mode = 2; n_first = 1;
        if (de_in) take_pixel(1);
      end
    end else if (m_mode == 2) begin
      if (rise) n_first = 1;
      if (de_in) take_pixel(rise ? 1'b1 : m_first);
    end else begin
      if (rise) n_mode = 0;
    end
  endfunction

  function automatic void drive_fifo();
    fifo_bus.fifo_empty = (q.size() == 0);
    fifo_bus.fifo_data  = (q.size() != 0) ? q[0] : '0;
  endfunction

  task automatic cycle(input logic v, input logic h, input logic d);
    @(posedge clk);
    #1;
    if (rd_seen && q.size() != 0) void'(q.pop_front());
    model_commit();
    vs_in = v; hs_in = h; de_in = d;
    drive_fifo();
    model_eval();
  endtask

  task automatic frame(input int w, input int h);
    seen.delete();
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    for (int l = 0; l < h; l++) begin
      cycle(0, 1, 0);
      cycle(0, 0, 0);
      for (int p = 0; p < w; p++) cycle(0, 0, 1);
      cycle(0, 0, 0);
    end
    cycle(0, 0, 0);
  endtask

  task automatic push_frame(input int base, input int n);
    logic [DATA_W:0] wd;
    for (int i = 0; i < n; i++) begin
      wd = {(i == 0) ? 1'b1 : 1'b0, DATA_W'(base + i)};
      q.push_back(wd);
    end
  endtask

  function automatic void check_frame(string name, int base, int nsrc, int total);
    logic [DATA_W-1:0] e;
    check({name, "_npix"}, seen.size(), total);
    for (int i = 0; i < seen.size() && i < total; i++) begin
      e = (i < nsrc) ? DATA_W'(base + i) : FILL;
      check({name, "_pix"}, seen[i], e);
    end
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (en) begin
      rd_seen = fifo_bus.fifo_rd;
      check("fifo_rd", fifo_bus.fifo_rd, exp_rd);
      check("vs_out", vs_out, m_vs);
      check("hs_out", hs_out, m_hs);
      check("de_out", de_out, m_de);
      check("rgb_out", rgb_out, m_rgb);
      check("locked", locked, (m_mode == 2));
      check("underflow_cnt", underflow_cnt, m_uf);
      check("sof_err_cnt", sof_err_cnt, m_se);
      if (de_out) seen.push_back(rgb_out);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d/%0d so far", npass, ntotal);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W:0] wd;
    rst = 1'b1; vs_in = 0; hs_in = 0; de_in = 0;
    wd = {1'b0, 24'h000111}; q.push_back(wd);
    wd = {1'b0, 24'h000222}; q.push_back(wd);
    push_frame(0, 8);
    drive_fifo();
    model_reset();
    #1;
    check("reset_rd", fifo_bus.fifo_rd, 0);
    check("reset_rgb", rgb_out, 0);
    check("reset_locked", locked, 0);
    check("reset_uf", underflow_cnt, 0);
    check("reset_se", sof_err_cnt, 0);
    en = 1'b1;

    // 1: stale words dropped, SOF held, clean 4x2 frame
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    rst = 1'b0;
    model_eval();
    repeat (4) cycle(0, 0, 0);
    check("s1_stale_dropped", q.size(), 8);
    frame(4, 2);
    check_frame("s1", 0, 8, 8);
    check("s1_locked", locked, 1);
    check("s1_uf", underflow_cnt, 0);
    check("s1_se", sof_err_cnt, 0);

    // 2: FIFO runs dry after 5 pixels, then relock a frame later
    push_frame(24'h10, 5);
    frame(4, 2);
    check_frame("s2", 24'h10, 5, 8);
    check("s2_uf", underflow_cnt, 1);
    check("s2_unlocked", locked, 0);
    push_frame(24'h20, 8);
    frame(4, 2);
    check_frame("s2_seek", 0, 0, 8);
    frame(4, 2);
    check_frame("s2_relock", 24'h20, 8, 8);
    check("s2_locked", locked, 1);

    // 3: one extra word before the next SOF
    push_frame(24'h30, 8);
    wd = {1'b0, 24'h000099}; q.push_back(wd);
    push_frame(24'h40, 8);
    frame(4, 2);
    check_frame("s3_a", 24'h30, 8, 8);
    frame(4, 2);
    check_frame("s3_err", 0, 0, 8);
    check("s3_se", sof_err_cnt, 1);
    frame(4, 2);
    check_frame("s3_seek", 0, 0, 8);
    frame(4, 2);
    check_frame("s3_relock", 24'h40, 8, 8);

    // 4: SOF shows up at pixel 3
    push_frame(24'h50, 3);
    push_frame(24'h60, 8);
    frame(4, 2);
    check_frame("s4_early_sof", 24'h50, 3, 8);
    check("s4_se", sof_err_cnt, 2);
    check("s4_uf", underflow_cnt, 1);
    frame(4, 2);
    frame(4, 2);
    check_frame("s4_relock", 24'h60, 8, 8);

    // 5: asynchronous reset in the middle of an active line
    push_frame(24'h70, 8);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    #1;
    check("s5_rd_before", fifo_bus.fifo_rd, 1);
    check("s5_de_before", de_out, 1);
    rst = 1'b1;
    model_reset();
    #1;
    check("s5_rd", fifo_bus.fifo_rd, 0);
    check("s5_rgb", rgb_out, 0);
    check("s5_de", de_out, 0);
    check("s5_locked", locked, 0);
    check("s5_se", sof_err_cnt, 0);
    check("s5_uf", underflow_cnt, 0);
    cycle(0, 0, 0);
    rst = 1'b0;
    model_eval();
    repeat (8) cycle(0, 0, 0);
    check("s5_flushed", q.size(), 0);
    check("s5_unlocked", locked, 0);

    // 6: 2^CNT_W + 3 underflow events saturate the counter
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      wd = {1'b1, DATA_W'(i)};
      q.push_back(wd);
      frame(2, 1);
      frame(2, 1);
    end
    check("s6_uf_sat", underflow_cnt, 4'hF);
    check("s6_se", sof_err_cnt, 0);

    en = 1'b0;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
